// File: rtl/drp_arb_pkg.sv
// Shared types and constants for the DRP port arbiter.
package drp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned DRP_DATA_W   = 16;
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/drp_port_arbiter.sv
// Round-robin arbiter sharing one GT DRP port between the Wishbone DRP bridge
// (requester 0) and the transceiver init/tuning sequencer (requester 1).
// One transaction in flight; completion is a success or a timeout.
module drp_port_arbiter
  import drp_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [1:0]              req_valid_i,
  input  logic [1:0]              req_we_i,
  input  logic [2*ADDR_W-1:0]     req_addr_i,
  input  logic [2*DRP_DATA_W-1:0] req_di_i,
  output logic [1:0]              req_ready_o,
  output logic [1:0]              rsp_valid_o,
  output logic [DRP_DATA_W-1:0]   rsp_data_o,
  output logic                    rsp_timeout_o,
  output logic                    stale_o,
  output logic                    drpen_o,
  output logic                    drpwe_o,
  output logic [ADDR_W-1:0]       drpaddr_o,
  output logic [DRP_DATA_W-1:0]   drpdi_o,
  input  logic                    drprdy_i,
  input  logic [DRP_DATA_W-1:0]   drpdo_i
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e                  state_q, state_d;
  logic                    gnt;
  logic                    accept;
  logic                    last_grant_q;
  logic                    grant_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DRP_DATA_W-1:0]   di_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    cnt_done;
  logic [DRP_DATA_W-1:0]   rsp_data_q;
  logic                    rsp_timeout_q;
  logic                    stale_q;

  assign cnt_done = (cnt_q == CNT_MAX);

  // Next-state, grant selection and accept strobe.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    req_ready_o = 2'b00;
    // On a tie the requester not served last wins; otherwise the only valid one.
    gnt         = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
    unique case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          accept      = 1'b1;
          req_ready_o = gnt ? 2'b10 : 2'b01;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (drprdy_i || cnt_done) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch and round-robin history, loaded on accept.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      di_q         <= '0;
    end else if (accept) begin
      last_grant_q <= gnt;
      grant_q      <= gnt;
      we_q         <= gnt ? req_we_i[1] : req_we_i[0];
      addr_q       <= gnt ? req_addr_i[ADDR_W +: ADDR_W] : req_addr_i[0 +: ADDR_W];
      di_q         <= gnt ? req_di_i[DRP_DATA_W +: DRP_DATA_W] : req_di_i[0 +: DRP_DATA_W];
    end
  end

  // Timeout counter: cleared while issuing, saturating count while waiting.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT && !drprdy_i && !cnt_done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Response capture; a ready on the timeout cycle still counts as success.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (state_q == WAIT) begin
      if (drprdy_i) begin
        rsp_data_q    <= drpdo_i;
        rsp_timeout_q <= 1'b0;
      end else if (cnt_done) begin
        rsp_data_q    <= TIMEOUT_DATA;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  // Sticky flag for a ready that arrives with nothing outstanding.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stale_q <= 1'b0;
    end else if (drprdy_i && state_q != WAIT) begin
      stale_q <= 1'b1;
    end
  end

  // DRP side is decoded from state so an async reset drops drpen at once.
  assign drpen_o       = (state_q == ISSUE);
  assign drpwe_o       = drpen_o & we_q;
  assign drpaddr_o     = addr_q;
  assign drpdi_o       = di_q;
  assign rsp_valid_o   = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign stale_o       = stale_q;

endmodule
